// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared state encoding, width helper and default parameters for the bus arbiter
package bus_arb_pkg;
    localparam int DEF_NUM_MASTERS = 2;
    localparam int DEF_NUM_SLAVES = 3;
    localparam int DEF_TIMEOUT_CYCLES = 4096;
    typedef enum logic [1:0] {IDLE, WAIT_SLV, OWN, RELEASE} state_t;
    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_bus_arbiter_picker.sv
// rr_picker: rotating-priority encoder, the first set request at or after start wins
module rr_picker import bus_arb_pkg::*; #(
    parameter int N = 2,
    parameter int W = clog2w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         valid
);
    logic [W-1:0] c;
    // scan from the farthest position back toward start so the nearest request is assigned last
    always_comb begin
        idx = '0;
        c = '0;
        valid = |req;
        for (int k = N - 1; k >= 0; k--) begin
            c = W'((int'(start) + k) % N);
            if (req[c]) idx = c;
        end
    end
endmodule

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin bus arbiter granting one master at a time to a ready slave
module rr_bus_arbiter import bus_arb_pkg::*; #(
    parameter int NUM_MASTERS = DEF_NUM_MASTERS,
    parameter int NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int MW = clog2w(NUM_MASTERS),
    localparam int SW = clog2w(NUM_SLAVES)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_MASTERS-1:0]    m_request,
    input  logic [NUM_MASTERS*SW-1:0] m_slave_select,
    input  logic [NUM_MASTERS-1:0]    m_tx_done,
    input  logic [NUM_SLAVES-1:0]     slave_ready,
    output logic [NUM_MASTERS-1:0]    m_grant,
    output logic [MW-1:0]             bus_grant,
    output logic [SW-1:0]             slave_grant,
    output logic                      busy,
    output logic                      timeout,
    output logic                      sel_error
);
    localparam int CW = clog2w(TIMEOUT_CYCLES);

    state_t state, state_n;
    logic [MW-1:0] owner, owner_n, last_owner, last_owner_n, start, raw_idx, win_idx, bus_grant_n;
    logic [SW-1:0] slv, slv_n, slave_grant_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [NUM_MASTERS-1:0] valid_req, m_grant_n;
    logic raw_valid, win_valid, done, last_cycle, timeout_n, sel_error_n;

    assign start = (last_owner == MW'(NUM_MASTERS - 1)) ? '0 : last_owner + 1'b1;
    assign done = m_tx_done[owner];
    assign last_cycle = cnt == CW'(TIMEOUT_CYCLES - 1);

    // requests naming a nonexistent slave never take part in arbitration
    always_comb begin
        valid_req = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            valid_req[i] = m_request[i] && ({1'b0, m_slave_select[i*SW +: SW]} < (SW + 1)'(NUM_SLAVES));
    end

    // the raw pick only detects a bad select; the masked pick chooses the actual winner
    rr_picker #(.N(NUM_MASTERS), .W(MW)) raw_pick (.req(m_request), .start(start), .idx(raw_idx), .valid(raw_valid));
    rr_picker #(.N(NUM_MASTERS), .W(MW)) win_pick (.req(valid_req), .start(start), .idx(win_idx), .valid(win_valid));

    // next-state and next-output logic; outputs are registered from these values
    always_comb begin
        state_n = state;
        owner_n = owner;
        slv_n = slv;
        last_owner_n = last_owner;
        bus_grant_n = bus_grant;
        slave_grant_n = slave_grant;
        timeout_n = 1'b0;
        sel_error_n = 1'b0;
        case (state)
            IDLE: begin
                sel_error_n = raw_valid && !valid_req[raw_idx];
                if (win_valid) begin
                    state_n = WAIT_SLV;
                    owner_n = win_idx;
                    slv_n = m_slave_select[int'(win_idx)*SW +: SW];
                end
            end
            WAIT_SLV: begin
                if (!m_request[owner]) state_n = IDLE;
                else if (slave_ready[slv]) begin
                    state_n = OWN;
                    bus_grant_n = owner;
                    slave_grant_n = slv;
                end
            end
            OWN: begin
                timeout_n = last_cycle && !done && m_request[owner];
                if (done || !m_request[owner] || last_cycle) state_n = RELEASE;
            end
            default: begin
                state_n = IDLE;
                last_owner_n = owner;
            end
        endcase
        cnt_n = (state == OWN && state_n == OWN) ? cnt + 1'b1 : '0;
        m_grant_n = (state_n == OWN) ? NUM_MASTERS'(1) << owner_n : '0;
    end

    // state and registered outputs; reset drops every grant without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            slv <= '0;
            last_owner <= MW'(NUM_MASTERS - 1);
            cnt <= '0;
            m_grant <= '0;
            bus_grant <= '0;
            slave_grant <= '0;
            busy <= 1'b0;
            timeout <= 1'b0;
            sel_error <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            slv <= slv_n;
            last_owner <= last_owner_n;
            cnt <= cnt_n;
            m_grant <= m_grant_n;
            bus_grant <= bus_grant_n;
            slave_grant <= slave_grant_n;
            busy <= state_n != IDLE;
            timeout <= timeout_n;
            sel_error <= sel_error_n;
        end
    end
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter: directed and randomized checks of rr_bus_arbiter against a transaction-level model
module tb_rr_bus_arbiter;
    localparam int NM = 2;
    localparam int NS = 3;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [NM-1:0] req = '0;
    logic [NM-1:0] done = '0;
    logic [2*NM-1:0] sel_bus = '0;
    logic [NS-1:0] ready = '0;
    logic [NM-1:0] m_grant;
    logic bus_grant;
    logic [1:0] slave_grant;
    logic busy, timeout, sel_error;
    int checks = 0;
    int errors = 0;

    rr_bus_arbiter #(.NUM_MASTERS(NM), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .m_request(req), .m_slave_select(sel_bus), .m_tx_done(done),
        .slave_ready(ready), .m_grant(m_grant), .bus_grant(bus_grant), .slave_grant(slave_grant),
        .busy(busy), .timeout(timeout), .sel_error(sel_error));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // transaction-level model: phase 0 free, 1 waiting for slave, 2 owning, 3 releasing
    int ph = 0, own = 0, oslv = 0, last = NM - 1, age = 0;
    int e_bg = 0, e_sg = 0, e_to = 0, e_se = 0;

    function automatic int sel_of(input int m);
        return int'(sel_bus[m*2 +: 2]);
    endfunction

    task automatic model_step();
        int first, firstv, m;
        e_to = 0;
        e_se = 0;
        if (reset) begin
            ph = 0; own = 0; oslv = 0; last = NM - 1; age = 0; e_bg = 0; e_sg = 0;
        end else if (ph == 0) begin
            first = -1;
            firstv = -1;
            for (int k = 0; k < NM; k++) begin
                m = (last + 1 + k) % NM;
                if (req[m] && first < 0) first = m;
                if (req[m] && sel_of(m) < NS && firstv < 0) firstv = m;
            end
            if (first >= 0) e_se = (sel_of(first) >= NS) ? 1 : 0;
            if (firstv >= 0) begin ph = 1; own = firstv; oslv = sel_of(firstv); end
        end else if (ph == 1) begin
            if (!req[own]) ph = 0;
            else if (ready[oslv]) begin ph = 2; age = 1; e_bg = own; e_sg = oslv; end
        end else if (ph == 2) begin
            if (done[own] || !req[own] || age == TO) begin
                e_to = (age == TO && !done[own] && req[own]) ? 1 : 0;
                ph = 3;
            end else age++;
        end else begin
            ph = 0;
            last = own;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("m_grant", m_grant, (ph == 2) ? (1 << own) : 0);
        chk("bus_grant", bus_grant, e_bg);
        chk("slave_grant", slave_grant, e_sg);
        chk("busy", busy, (ph != 0) ? 1 : 0);
        chk("timeout", timeout, e_to);
        chk("sel_error", sel_error, e_se);
        chk("onehot0", $onehot0(m_grant), 1);
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        req = '0;
        done = '0;
        #2 reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    task automatic wait_grant(input logic [NM-1:0] g, input int lim, input string nm);
        int n = 0;
        while (m_grant !== g && n < lim) begin
            cyc(1);
            n++;
        end
        chk(nm, m_grant, g);
    endtask

    initial begin
        int n, age_d, tcount;
        logic [NM-1:0] prev;
        logic [NM-1:0] seq [4];
        logic [NM-1:0] drop;
        int hold [NM];
        cyc(2);
        chk("rst_grant", m_grant, 0);
        chk("rst_bus_grant", bus_grant, 0);
        chk("rst_slave_grant", slave_grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_sel_error", sel_error, 0);
        reset = 1'b0;
        // single master, slave 1 ready
        ready = 3'b111;
        sel_bus = 4'b0001;
        req = 2'b01;
        cyc(1);
        chk("basic_wait_busy", busy, 1);
        chk("basic_wait_grant", m_grant, 0);
        cyc(1);
        chk("basic_grant", m_grant, 2'b01);
        chk("basic_slave", slave_grant, 1);
        chk("basic_busy", busy, 1);
        done = 2'b01;
        cyc(1);
        done = '0;
        req = '0;
        chk("basic_dead_grant", m_grant, 0);
        chk("basic_dead_busy", busy, 1);
        cyc(1);
        chk("basic_idle_busy", busy, 0);
        // two masters alternate
        do_reset();
        sel_bus = 4'b1000;
        req = 2'b11;
        n = 0;
        age_d = 0;
        prev = '0;
        seq = '{default: '0};
        for (int c = 0; c < 80 && n < 4; c++) begin
            cyc(1);
            done = '0;
            if (m_grant != 0 && prev == 0) begin
                seq[n] = m_grant;
                n++;
                age_d = 0;
            end
            if (m_grant != 0) begin
                age_d++;
                if (age_d == 3) done = m_grant;
            end
            prev = m_grant;
        end
        chk("alt_count", n, 4);
        chk("alt_0", seq[0], 2'b01);
        chk("alt_1", seq[1], 2'b10);
        chk("alt_2", seq[2], 2'b01);
        chk("alt_3", seq[3], 2'b10);
        req = '0;
        done = '0;
        cyc(4);
        // ownership timeout
        sel_bus = 4'b0000;
        req = 2'b10;
        wait_grant(2'b10, 6, "to_m1_grant");
        req = 2'b11;
        n = 0;
        tcount = 0;
        for (int c = 0; c < 20 && m_grant == 2'b10; c++) begin
            n++;
            cyc(1);
            tcount += int'(timeout);
        end
        chk("to_own_cycles", n, 8);
        chk("to_pulse", timeout, 1);
        chk("to_dead_busy", busy, 1);
        chk("to_pulse_count", tcount, 1);
        cyc(1);
        chk("to_pulse_end", timeout, 0);
        wait_grant(2'b01, 6, "to_m0_after");
        req = '0;
        cyc(4);
        // invalid select is skipped
        do_reset();
        sel_bus = 4'b0011;
        req = 2'b11;
        cyc(1);
        chk("sel_err_pulse", sel_error, 1);
        chk("sel_busy", busy, 1);
        cyc(1);
        chk("sel_m1_grant", m_grant, 2'b10);
        chk("sel_err_clear", sel_error, 0);
        done = 2'b10;
        cyc(1);
        done = '0;
        req = 2'b01;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(1);
            if (m_grant[0]) n++;
        end
        chk("sel_m0_never", n, 0);
        chk("sel_err_idle", sel_error, 1);
        chk("sel_idle_busy", busy, 0);
        req = '0;
        cyc(2);
        // slave not ready, then abort while waiting
        do_reset();
        ready = 3'b011;
        sel_bus = 4'b0010;
        req = 2'b01;
        for (int c = 0; c < 5; c++) begin
            cyc(1);
            chk("rdy_wait_grant", m_grant, 0);
            chk("rdy_wait_busy", busy, 1);
        end
        ready = 3'b111;
        cyc(1);
        chk("rdy_grant", m_grant, 2'b01);
        chk("rdy_slave", slave_grant, 2);
        req = '0;
        cyc(3);
        ready = 3'b011;
        req = 2'b01;
        cyc(2);
        req = '0;
        cyc(1);
        chk("abort_busy", busy, 0);
        chk("abort_grant", m_grant, 0);
        ready = 3'b111;
        // asynchronous reset mid-ownership
        do_reset();
        sel_bus = 4'b0100;
        req = 2'b10;
        wait_grant(2'b10, 6, "ar_m1_own");
        cyc(1);
        #2 reset = 1'b1;
        #1;
        chk("ar_grant", m_grant, 0);
        chk("ar_bus_grant", bus_grant, 0);
        chk("ar_slave_grant", slave_grant, 0);
        chk("ar_busy", busy, 0);
        req = 2'b11;
        sel_bus = 4'b0000;
        cyc(2);
        reset = 1'b0;
        cyc(2);
        chk("ar_m0_first", m_grant, 2'b01);
        req = '0;
        cyc(4);
        // randomized traffic
        do_reset();
        drop = '0;
        hold = '{default: 0};
        for (int c = 0; c < 4000; c++) begin
            cyc(1);
            for (int s = 0; s < NS; s++) ready[s] = ($urandom_range(3) != 0);
            done = '0;
            for (int i = 0; i < NM; i++) begin
                if (drop[i]) begin
                    req[i] = 1'b0;
                    drop[i] = 1'b0;
                end else if (!req[i]) begin
                    sel_bus[i*2 +: 2] = 2'($urandom_range(3));
                    if ($urandom_range(3) == 0) begin
                        req[i] = 1'b1;
                        hold[i] = $urandom_range(1, 11);
                    end else if ($urandom_range(15) == 0) done[i] = 1'b1;
                end else if (ph == 2 && own == i) begin
                    hold[i]--;
                    if (hold[i] <= 0) begin
                        if ($urandom_range(3) == 0) req[i] = 1'b0;
                        else begin
                            done[i] = 1'b1;
                            drop[i] = 1'b1;
                        end
                    end
                end else if ($urandom_range(15) == 0) req[i] = 1'b0;
                else if ($urandom_range(15) == 0) done[i] = 1'b1;
            end
        end
        req = '0;
        done = '0;
        cyc(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
